// File: rtl/matvec_sequencer_if.sv
// Handshake bundle between the matrix-vector sequencer and its producers/consumers.
// master = sequencer side, slave = environment (x/row source, inner_product unit, y sink).
interface matvec_sequencer_if #(
   parameter int N = 4,
   parameter int M = 2
);
   logic [N-1:0][31:0] input_x;
   logic               input_x_stb;
   logic               input_x_ack;
   logic [N-1:0][31:0] input_row;
   logic               input_row_stb;
   logic               input_row_ack;
   logic [N-1:0][31:0] ip_v1;
   logic [N-1:0][31:0] ip_v2;
   logic               ip_v1_stb;
   logic               ip_v2_stb;
   logic               ip_v1_ack;
   logic               ip_v2_ack;
   logic [31:0]        ip_prod;
   logic               ip_prod_stb;
   logic               ip_prod_ack;
   logic [M-1:0][31:0] output_y;
   logic               output_y_stb;
   logic               output_y_ack;

   modport master (
      input  input_x, input_x_stb, output input_x_ack,
      input  input_row, input_row_stb, output input_row_ack,
      output ip_v1, ip_v2, ip_v1_stb, ip_v2_stb,
      input  ip_v1_ack, ip_v2_ack,
      input  ip_prod, ip_prod_stb, output ip_prod_ack,
      output output_y, output_y_stb, input output_y_ack
   );

   modport slave (
      output input_x, input_x_stb, input input_x_ack,
      output input_row, input_row_stb, input input_row_ack,
      input  ip_v1, ip_v2, ip_v1_stb, ip_v2_stb,
      output ip_v1_ack, ip_v2_ack,
      output ip_prod, ip_prod_stb, input ip_prod_ack,
      input  output_y, output_y_stb, output output_y_ack
   );
endinterface

// File: rtl/matvec_sequencer.sv
// y = W*x by feeding M rows through one shared inner_product unit; ~M*(3+L_ip) cycles per pass.
// Every handshake output is a register; each stage stalls indefinitely on its partner's ack/stb.
module matvec_sequencer #(
   parameter int N = 4,
   parameter int M = 2
) (
   input  logic             clk,
   input  logic             rst,
   matvec_sequencer_if.master bus
);
   localparam int RW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_ROW, ISSUE, WAIT_PROD, OUTPUT} state_t;

   state_t             state;
   logic [RW-1:0]      r;
   logic [N-1:0][31:0] x_vec;
   logic [N-1:0][31:0] row_vec;
   logic [M-1:0][31:0] y_vec;
   logic               x_ack;
   logic               row_ack;
   logic               v1_stb;
   logic               v2_stb;
   logic               prod_ack;
   logic               y_stb;

   assign bus.input_x_ack   = x_ack;
   assign bus.input_row_ack = row_ack;
   assign bus.ip_v1         = row_vec;
   assign bus.ip_v2         = x_vec;
   assign bus.ip_v1_stb     = v1_stb;
   assign bus.ip_v2_stb     = v2_stb;
   assign bus.ip_prod_ack   = prod_ack;
   assign bus.output_y      = y_vec;
   assign bus.output_y_stb  = y_stb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         r        <= '0;
         x_vec    <= '0;
         row_vec  <= '0;
         y_vec    <= '0;
         x_ack    <= 1'b0;
         row_ack  <= 1'b0;
         v1_stb   <= 1'b0;
         v2_stb   <= 1'b0;
         prod_ack <= 1'b0;
         y_stb    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // x_ack rises one cycle after reset release, then stays up until x is taken
               x_ack <= 1'b1;
               if (bus.input_x_stb && x_ack) begin
                  x_vec   <= bus.input_x;
                  r       <= '0;
                  x_ack   <= 1'b0;
                  row_ack <= 1'b1;
                  state   <= LOAD_ROW;
               end
            end
            LOAD_ROW: begin
               if (bus.input_row_stb && row_ack) begin
                  row_vec <= bus.input_row;
                  row_ack <= 1'b0;
                  v1_stb  <= 1'b1;
                  v2_stb  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (v1_stb && bus.ip_v1_ack) v1_stb <= 1'b0;
               if (v2_stb && bus.ip_v2_ack) v2_stb <= 1'b0;
               // both operands may complete in the same cycle or in separate ones
               if ((!v1_stb || bus.ip_v1_ack) && (!v2_stb || bus.ip_v2_ack)) begin
                  prod_ack <= 1'b1;
                  state    <= WAIT_PROD;
               end
            end
            WAIT_PROD: begin
               if (bus.ip_prod_stb && prod_ack) begin
                  for (int i = 0; i < M; i++) begin
                     if (r == RW'(i)) y_vec[i] <= bus.ip_prod;
                  end
                  prod_ack <= 1'b0;
                  if (r == RW'(M - 1)) begin
                     y_stb <= 1'b1;
                     state <= OUTPUT;
                  end else begin
                     r       <= r + RW'(1);
                     row_ack <= 1'b1;
                     state   <= LOAD_ROW;
                  end
               end
            end
            OUTPUT: begin
               if (y_stb && bus.output_y_ack) begin
                  y_stb <= 1'b0;
                  x_ack <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: N=4/M=2 and N=1/M=1 instances, bench-side float inner_product model.
module tb_matvec_sequencer;
   typedef logic [3:0][31:0]      vec_t;
   typedef logic [1:0][3:0][31:0] mat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [63:0] sb_a[$];
   logic [31:0] sb_b[$];
   logic [63:0] y_exp;

   always #5 clk = ~clk;

   matvec_sequencer_if #(.N(4), .M(2)) a();
   matvec_sequencer_if #(.N(1), .M(1)) b();

   matvec_sequencer #(.N(4), .M(2)) dut_a (.clk(clk), .rst(rst), .bus(a.master));
   matvec_sequencer #(.N(1), .M(1)) dut_b (.clk(clk), .rst(rst), .bus(b.master));

   localparam vec_t X1  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
   localparam mat_t W1  = {{32'h40C00000, 32'h40A00000, 32'h41000000, 32'h40E00000},
                           {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000}};
   localparam vec_t X2  = {32'h40400000, 32'h40000000, 32'hBF800000, 32'h3F000000};
   localparam mat_t W2  = {{32'h3F800000, 32'h3F800000, 32'h00000000, 32'hC0000000},
                           {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}};
   localparam vec_t JNK = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};

   function automatic real f2r(input logic [31:0] v);
      real m;
      int  e;
      if (v[30:0] == 31'd0) return 0.0;
      m = 1.0 + real'(v[22:0]) / 8388608.0;
      e = int'(v[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return v[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real v);
      real         m;
      int          e;
      logic        s;
      logic [31:0] mant;
      s = (v < 0.0);
      m = s ? -v : v;
      if (m == 0.0) return 32'd0;
      e = 127;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      mant = 32'(longint'((m - 1.0) * 8388608.0));
      return {s, 8'(e), mant[22:0]};
   endfunction

   function automatic logic [31:0] dot4(input vec_t p, input vec_t q);
      real acc = 0.0;
      for (int j = 0; j < 4; j++) acc = acc + f2r(p[j]) * f2r(q[j]);
      return r2f(acc);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_x(input vec_t v);
      int n = 0;
      a.input_x = v;
      a.input_x_stb = 1'b1;
      while (!a.input_x_ack && n < 50) begin tick; n++; end
      chk("x_accept", 128'(a.input_x_ack), 128'(1));
      tick;
      a.input_x_stb = 1'b0;
   endtask

   task automatic send_row(input vec_t v);
      int n = 0;
      a.input_row = v;
      a.input_row_stb = 1'b1;
      while (!a.input_row_ack && n < 50) begin tick; n++; end
      chk("row_accept", 128'(a.input_row_ack), 128'(1));
      tick;
      a.input_row_stb = 1'b0;
   endtask

   task automatic issue(input vec_t row, input vec_t x, input int v2_delay);
      int n = 0;
      while (!a.ip_v1_stb && n < 50) begin tick; n++; end
      chk("v1_stb_up", 128'(a.ip_v1_stb), 128'(1));
      chk("v2_stb_up", 128'(a.ip_v2_stb), 128'(1));
      chk("ip_v1", 128'(a.ip_v1), 128'(row));
      chk("ip_v2", 128'(a.ip_v2), 128'(x));
      a.ip_v1_ack = 1'b1;
      a.ip_v2_ack = (v2_delay == 0);
      tick;
      a.ip_v1_ack = 1'b0;
      chk("v1_stb_drop", 128'(a.ip_v1_stb), 128'(0));
      if (v2_delay > 0) begin
         for (int k = 1; k < v2_delay; k++) begin
            chk("v2_stb_held", 128'(a.ip_v2_stb), 128'(1));
            tick;
         end
         chk("v2_stb_held", 128'(a.ip_v2_stb), 128'(1));
         a.ip_v2_ack = 1'b1;
         tick;
      end
      a.ip_v2_ack = 1'b0;
      chk("v2_stb_drop", 128'(a.ip_v2_stb), 128'(0));
   endtask

   task automatic prod(input logic [31:0] p);
      int n = 0;
      a.ip_prod = p;
      a.ip_prod_stb = 1'b1;
      while (!a.ip_prod_ack && n < 50) begin tick; n++; end
      chk("prod_accept", 128'(a.ip_prod_ack), 128'(1));
      tick;
      a.ip_prod_stb = 1'b0;
   endtask

   task automatic pass_a(input vec_t x, input mat_t w, input int v2_delay, input int y_hold, input bit junk_x);
      int          n = 0;
      logic [63:0] e;
      sb_a.push_back({dot4(w[1], x), dot4(w[0], x)});
      send_x(x);
      if (junk_x) begin
         a.input_x = JNK;
         a.input_x_stb = 1'b1;
         for (int k = 0; k < 3; k++) begin
            chk("x_ack_in_load_row", 128'(a.input_x_ack), 128'(0));
            tick;
         end
         a.input_x_stb = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         send_row(w[i]);
         issue(w[i], x, v2_delay);
         prod(dot4(w[i], x));
      end
      while (!a.output_y_stb && n < 50) begin tick; n++; end
      chk("y_stb_up", 128'(a.output_y_stb), 128'(1));
      chk("sb_nonempty", 128'(sb_a.size() > 0), 128'(1));
      e = sb_a.pop_front();
      chk("output_y", 128'(a.output_y), 128'(e));
      for (int k = 0; k < y_hold; k++) begin
         tick;
         chk("y_stb_stall", 128'(a.output_y_stb), 128'(1));
         chk("y_stall_stable", 128'(a.output_y), 128'(e));
         chk("x_ack_stall", 128'(a.input_x_ack), 128'(0));
      end
      a.output_y_ack = 1'b1;
      tick;
      a.output_y_ack = 1'b0;
      chk("y_stb_single", 128'(a.output_y_stb), 128'(0));
      chk("x_ack_back2back", 128'(a.input_x_ack), 128'(1));
   endtask

   initial begin
      int n;
      a.input_x = '0;  a.input_x_stb = 1'b0;  a.input_row = '0;  a.input_row_stb = 1'b0;
      a.ip_v1_ack = 1'b0;  a.ip_v2_ack = 1'b0;  a.ip_prod = '0;  a.ip_prod_stb = 1'b0;
      a.output_y_ack = 1'b0;
      b.input_x = '0;  b.input_x_stb = 1'b0;  b.input_row = '0;  b.input_row_stb = 1'b0;
      b.ip_v1_ack = 1'b0;  b.ip_v2_ack = 1'b0;  b.ip_prod = '0;  b.ip_prod_stb = 1'b0;
      b.output_y_ack = 1'b0;

      // reset state
      repeat (3) tick;
      chk("rst_x_ack", 128'(a.input_x_ack), 128'(0));
      chk("rst_row_ack", 128'(a.input_row_ack), 128'(0));
      chk("rst_v1_stb", 128'(a.ip_v1_stb), 128'(0));
      chk("rst_v2_stb", 128'(a.ip_v2_stb), 128'(0));
      chk("rst_prod_ack", 128'(a.ip_prod_ack), 128'(0));
      chk("rst_y_stb", 128'(a.output_y_stb), 128'(0));
      chk("rst_y", 128'(a.output_y), 128'(0));
      chk("rst_ip_v1", 128'(a.ip_v1), 128'(0));
      rst = 1'b1;
      tick;
      chk("x_ack_after_rst", 128'(a.input_x_ack), 128'(1));

      // reference pass with all partners ready
      pass_a(X1, W1, 0, 0, 1'b0);
      y_exp = {32'h42780000, 32'h428C0000};
      chk("y_ref_const", 128'(a.output_y), 128'(y_exp));

      // a row offered in IDLE is ignored; an x offered in LOAD_ROW is ignored
      a.input_row = JNK;
      a.input_row_stb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("row_ack_in_idle", 128'(a.input_row_ack), 128'(0));
         chk("row_reg_kept", 128'(a.ip_v1), 128'(W1[1]));
         tick;
      end
      a.input_row_stb = 1'b0;
      pass_a(X1, W1, 0, 0, 1'b1);

      // operand acks split, y backpressure, different data
      pass_a(X1, W1, 3, 0, 1'b0);
      pass_a(X1, W1, 0, 20, 1'b0);
      pass_a(X2, W2, 1, 2, 1'b0);

      // reset during ISSUE of row 1
      send_x(X1);
      send_row(W1[0]);
      issue(W1[0], X1, 0);
      prod(dot4(W1[0], X1));
      send_row(W1[1]);
      n = 0;
      while (!a.ip_v1_stb && n < 50) begin tick; n++; end
      chk("row1_issue", 128'(a.ip_v1_stb), 128'(1));
      rst = 1'b0;
      #1;
      chk("midrst_v1_stb", 128'(a.ip_v1_stb), 128'(0));
      chk("midrst_v2_stb", 128'(a.ip_v2_stb), 128'(0));
      chk("midrst_y", 128'(a.output_y), 128'(0));
      chk("midrst_x_ack", 128'(a.input_x_ack), 128'(0));
      #2;
      rst = 1'b1;
      tick;
      a.ip_prod = 32'h3F800000;
      a.ip_prod_stb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("stale_prod_ignored", 128'(a.ip_prod_ack), 128'(0));
         tick;
      end
      a.ip_prod_stb = 1'b0;
      pass_a(X1, W1, 0, 0, 1'b0);

      // N=1, M=1 instance: WAIT_PROD goes straight to OUTPUT
      sb_b.push_back(r2f(f2r(32'h40000000) * f2r(32'h40E00000)));
      b.input_x = 32'h40000000;
      b.input_x_stb = 1'b1;
      n = 0;
      while (!b.input_x_ack && n < 50) begin tick; n++; end
      chk("b_x_accept", 128'(b.input_x_ack), 128'(1));
      tick;
      b.input_x_stb = 1'b0;
      b.input_row = 32'h40E00000;
      b.input_row_stb = 1'b1;
      n = 0;
      while (!b.input_row_ack && n < 50) begin tick; n++; end
      chk("b_row_accept", 128'(b.input_row_ack), 128'(1));
      tick;
      b.input_row_stb = 1'b0;
      chk("b_v1_stb", 128'(b.ip_v1_stb), 128'(1));
      chk("b_ip_v1", 128'(b.ip_v1), 128'(32'h40E00000));
      chk("b_ip_v2", 128'(b.ip_v2), 128'(32'h40000000));
      b.ip_v1_ack = 1'b1;
      b.ip_v2_ack = 1'b1;
      tick;
      b.ip_v1_ack = 1'b0;
      b.ip_v2_ack = 1'b0;
      b.ip_prod = r2f(14.0);
      b.ip_prod_stb = 1'b1;
      n = 0;
      while (!b.ip_prod_ack && n < 50) begin tick; n++; end
      chk("b_prod_accept", 128'(b.ip_prod_ack), 128'(1));
      tick;
      b.ip_prod_stb = 1'b0;
      chk("b_direct_output", 128'(b.output_y_stb), 128'(1));
      chk("b_no_next_row", 128'(b.input_row_ack), 128'(0));
      chk("b_sb_nonempty", 128'(sb_b.size() > 0), 128'(1));
      chk("b_output_y", 128'(b.output_y), 128'(sb_b.pop_front()));
      chk("b_y_const", 128'(b.output_y), 128'(32'h41600000));
      b.output_y_ack = 1'b1;
      tick;
      b.output_y_ack = 1'b0;
      chk("b_y_stb_drop", 128'(b.output_y_stb), 128'(0));
      chk("b_x_ack_back", 128'(b.input_x_ack), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/matvec_sequencer.md
MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

Interface
- REQ-001 SHALL have parameter N, default 4: vector length (elements per row and per x), N >= 1.
- REQ-002 SHALL have parameter M, default 2: number of matrix rows (elements of y), M >= 1.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have ports input_x (input, N x 32), input_x_stb (input, 1), input_x_ack (output, 1): operand vector x, IEEE-754 single.
- REQ-006 SHALL have ports input_row (input, N x 32), input_row_stb (input, 1), input_row_ack (output, 1): one matrix row per transfer, rows arrive in order 0..M-1.
- REQ-007 SHALL have ports ip_v1 (output, N x 32), ip_v2 (output, N x 32), ip_v1_stb (output, 1), ip_v2_stb (output, 1), ip_v1_ack (input, 1), ip_v2_ack (input, 1): operand side of the shared inner_product unit.
- REQ-008 SHALL have ports ip_prod (input, 32), ip_prod_stb (input, 1), ip_prod_ack (output, 1): result side of the inner_product unit.
- REQ-009 SHALL have ports output_y (output, M x 32), output_y_stb (output, 1), output_y_ack (input, 1): result vector y = W*x; element i = row i · x.

Function
- REQ-010 SHALL treat a transfer on any stb/ack pair as occurring in a cycle where both are high at the rising edge; stb, once raised, SHALL stay high with stable data until its transfer.
- REQ-011 SHALL implement states IDLE, LOAD_ROW, ISSUE, WAIT_PROD, OUTPUT.
- REQ-012 IDLE: input_x_ack=1; on x transfer latch x into register X, clear row counter r, go to LOAD_ROW.
- REQ-013 LOAD_ROW: input_row_ack=1; on row transfer latch row into register R, go to ISSUE.
- REQ-014 ISSUE: ip_v1=R, ip_v2=X; ip_v1_stb and ip_v2_stb each raised on entry and each dropped independently in the cycle after its own ack; go to WAIT_PROD once both transfers have completed (same or different cycles).
- REQ-015 WAIT_PROD: ip_prod_ack=1; on prod transfer write ip_prod into y[r]; if r==M-1 go to OUTPUT, else r<=r+1 and go to LOAD_ROW.
- REQ-016 OUTPUT: output_y_stb=1 with output_y stable; on transfer go to IDLE; stall indefinitely while output_y_ack=0.
- REQ-017 All ack/stb outputs SHALL be registered or decoded from state only, never combinationally from an input stb/ack.
- REQ-018 r SHALL be $clog2(M) bits (min 1) and SHALL never exceed M-1; for M=1 the sequencer goes WAIT_PROD -> OUTPUT directly.
- REQ-019 Minimum latency, all partners ready: x transfer to output_y_stb = M*(3 + L_ip) cycles, where L_ip is the inner_product operand-to-result latency.
- REQ-020 Inputs presented outside their accepting state SHALL be ignored (ack low, no register change).
- REQ-021 output_y SHALL hold the last completed vector until overwritten element-by-element in the next pass.
- REQ-022 Back-to-back: a new x SHALL be acceptable the cycle after the output_y transfer.

Reset
- REQ-023 rst low SHALL immediately force state=IDLE, r=0, X, R, y all zero, every stb and ack output low except input_x_ack (high only after rst deasserts, from IDLE decode).
- REQ-024 Reset asserted mid-operation SHALL abandon the pass; a product arriving after reset release SHALL not be acknowledged until a new pass reaches WAIT_PROD.

Verification
- REQ-025 N=4, M=2, x=[1,2,3,4], rows [5,6,7,8],[7,8,5,6], all partners always ready, real inner_product (N_THRESH=1) -> output_y={0x428C0000 (70), 0x42780000 (62)}, single output_y_stb pulse.
- REQ-026 Same stimulus, ip_v2_ack delayed 3 cycles after ip_v1_ack -> ip_v1_stb drops first, ip_v2_stb held 3 more cycles, same y.
- REQ-027 output_y_ack held low 20 cycles -> output_y_stb and output_y stable for 20 cycles, input_x_ack low throughout, then IDLE.
- REQ-028 N=1, M=1, x=[2], row [7] -> output_y=0x41600000 (14); row counter never increments.
- REQ-029 rst pulsed low during ISSUE of row 1 -> all stb low same cycle, y zero, next full pass with REQ-025 data yields correct y.
- REQ-030 input_row_stb high while in IDLE, input_x_stb high while in LOAD_ROW -> no ack, no register change.
